// File: rtl/io_port_unit_pkg.sv
// io_port_unit_pkg: shared CPU constants for the I/O port stage
package io_port_unit_pkg;
  localparam int IO_DW = 32;
  typedef enum logic [4:0] {
    OP_IN  = 5'b10110,
    OP_OUT = 5'b10111
  } io_opcode_e;
endpackage

// File: rtl/io_port_unit_if.sv
// io_port_unit_if: out-path stream from the port unit to the external consumer
interface io_port_unit_if import io_port_unit_pkg::*; #(
  parameter int DW = IO_DW,
  parameter int CW = 3
);
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_count;
  logic          out_overflow;
  modport master (output out_data, out_valid, out_count, out_overflow, input out_ready);
  modport slave  (input out_data, out_valid, out_count, out_overflow, output out_ready);
endinterface

// File: rtl/io_port_unit_sync_fifo.sv
// io_sync_fifo: out-path FIFO that accepts a write when full if a pop frees a slot the same cycle
module io_sync_fifo import io_port_unit_pkg::*; #(
  parameter int DW    = IO_DW,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          ready,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          valid,
  output logic [CW-1:0] count,
  output logic          drop
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop, acc;
  always_comb begin
    valid = cnt_q != '0;
    pop   = valid & ready;
    acc   = push & ((cnt_q != CW'(DEPTH)) | pop);
    drop  = push & ~acc;
    wr_d  = acc ? wr_q + AW'(1) : wr_q;
    rd_d  = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + CW'(acc) - CW'(pop);
    rdata = mem_q[rd_q];
    count = cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (acc) mem_q[wr_q] <= wdata;
  end
endmodule

// File: rtl/io_port_unit.sv
// io_port_unit: out-port FIFO driven by OutPort_enable edges, synchronised in-port capture
module io_port_unit import io_port_unit_pkg::*; #(
  parameter int DW    = IO_DW,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] bus_in,
  input  logic          OutPort_enable,
  input  logic          InPortout,
  input  logic [DW-1:0] ext_in_data,
  input  logic          ext_in_strobe,
  input  logic          clr_flags,
  output logic [DW-1:0] in_data_out,
  output logic          in_valid,
  output logic          in_overrun,
  io_port_unit_if.master o
);
  logic          oe_q, ipo_q, s1_q, s2_q, s3_q;
  logic [DW-1:0] in_reg_q, in_reg_d;
  logic          in_valid_q, in_valid_d, in_overrun_q, in_overrun_d;
  logic          out_overflow_q, out_overflow_d;
  logic          oe_rise, ip_rise, in_cap, drop;
  io_sync_fifo #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (oe_rise),
    .ready (o.out_ready),
    .wdata (bus_in),
    .rdata (o.out_data),
    .valid (o.out_valid),
    .count (o.out_count),
    .drop  (drop)
  );
  // a capture racing a read wins: the old value was consumed, so no overrun
  always_comb begin
    oe_rise        = OutPort_enable & ~oe_q;
    ip_rise        = InPortout & ~ipo_q;
    in_cap         = s2_q & ~s3_q;
    in_reg_d       = in_cap ? ext_in_data : in_reg_q;
    in_valid_d     = in_cap ? 1'b1 : ip_rise ? 1'b0 : in_valid_q;
    in_overrun_d   = (in_cap & in_valid_q & ~ip_rise) | (in_overrun_q & ~clr_flags);
    out_overflow_d = drop | (out_overflow_q & ~clr_flags);
    in_data_out    = in_reg_q;
    in_valid       = in_valid_q;
    in_overrun     = in_overrun_q;
    o.out_overflow = out_overflow_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oe_q           <= 1'b0;
      ipo_q          <= 1'b0;
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      in_reg_q       <= '0;
      in_valid_q     <= 1'b0;
      in_overrun_q   <= 1'b0;
      out_overflow_q <= 1'b0;
    end else begin
      oe_q           <= OutPort_enable;
      ipo_q          <= InPortout;
      s1_q           <= ext_in_strobe;
      s2_q           <= s1_q;
      s3_q           <= s2_q;
      in_reg_q       <= in_reg_d;
      in_valid_q     <= in_valid_d;
      in_overrun_q   <= in_overrun_d;
      out_overflow_q <= out_overflow_d;
    end
  end
endmodule
